// File: rtl/hazard_detection_if.sv
// rtl/hazard_detection_if.sv - pipeline-side signal bundle for the hazard detection unit
interface hazard_detection_if;
    logic [4:0] IF_ID_rs;
    logic [4:0] IF_ID_rt;
    logic       IF_ID_branch;
    logic       branch_taken;
    logic       ID_EX_mem_read;
    logic       ID_EX_reg_write;
    logic [4:0] ID_EX_rd;
    logic       EX_MEM_mem_read;
    logic [4:0] EX_MEM_rd;
    logic       pc_write;
    logic       if_id_write;
    logic       id_ex_flush;
    logic       if_id_flush;

    modport master (
        output IF_ID_rs, IF_ID_rt, IF_ID_branch, branch_taken,
        output ID_EX_mem_read, ID_EX_reg_write, ID_EX_rd,
        output EX_MEM_mem_read, EX_MEM_rd,
        input  pc_write, if_id_write, id_ex_flush, if_id_flush
    );

    modport slave (
        input  IF_ID_rs, IF_ID_rt, IF_ID_branch, branch_taken,
        input  ID_EX_mem_read, ID_EX_reg_write, ID_EX_rd,
        input  EX_MEM_mem_read, EX_MEM_rd,
        output pc_write, if_id_write, id_ex_flush, if_id_flush
    );
endinterface

// File: rtl/hazard_detection.sv
// rtl/hazard_detection.sv - stall/flush control with saturating event counters
module hazard_detection #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    hazard_detection_if.slave hz,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [0:0] state;
    logic [1:0] rem;
    logic       m_ex;
    logic       m_mem;
    logic [1:0] need;
    logic       stall;
    logic       flush;

    always_comb begin
        m_ex  = (hz.ID_EX_rd != 5'd0) &&
                ((hz.ID_EX_rd == hz.IF_ID_rs) || (hz.ID_EX_rd == hz.IF_ID_rt));
        m_mem = (hz.EX_MEM_rd != 5'd0) &&
                ((hz.EX_MEM_rd == hz.IF_ID_rs) || (hz.EX_MEM_rd == hz.IF_ID_rt));
    end

    // Later assignments win, so the 2-cycle rule is placed last.
    always_comb begin
        need = 2'd0;
        if (!hz.IF_ID_branch && hz.ID_EX_mem_read && m_ex)
            need = 2'd1;
        if (hz.IF_ID_branch && hz.EX_MEM_mem_read && m_mem)
            need = 2'd1;
        if (hz.IF_ID_branch && hz.ID_EX_reg_write && !hz.ID_EX_mem_read && m_ex)
            need = 2'd1;
        if (hz.IF_ID_branch && hz.ID_EX_mem_read && m_ex)
            need = 2'd2;
    end

    // branch_taken is computed from stale operands while stalled, so it is masked.
    always_comb begin
        stall = (state == HOLD) || (need != 2'd0);
        flush = !stall && hz.IF_ID_branch && hz.branch_taken;
    end

    always_comb begin
        hz.pc_write    = 1'b0;
        hz.if_id_write = 1'b0;
        hz.id_ex_flush = 1'b0;
        hz.if_id_flush = 1'b0;
        if (rstn) begin
            hz.pc_write    = !stall;
            hz.if_id_write = !stall;
            hz.id_ex_flush = stall;
            hz.if_id_flush = flush;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            rem   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (need == 2'd2) begin
                        state <= HOLD;
                        rem   <= 2'd1;
                    end
                end
                HOLD: begin
                    if (rem <= 2'd1) begin
                        state <= IDLE;
                        rem   <= 2'd0;
                    end else begin
                        rem <= rem - 2'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    rem   <= 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != CNT_MAX))
                stall_count <= stall_count + 1'b1;
            if (flush && (flush_count != CNT_MAX))
                flush_count <= flush_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_detection.sv
// tb/tb_hazard_detection.sv - directed self-checking bench for hazard_detection
module tb_hazard_detection;
    logic        clk;
    logic        rstn;
    logic [15:0] stall_count;
    logic [15:0] flush_count;
    logic [1:0]  stall_count2;
    logic [1:0]  flush_count2;
    int          tests_run;
    int          tests_failed;

    hazard_detection_if hz ();
    hazard_detection_if hz2 ();

    assign hz2.IF_ID_rs        = hz.IF_ID_rs;
    assign hz2.IF_ID_rt        = hz.IF_ID_rt;
    assign hz2.IF_ID_branch    = hz.IF_ID_branch;
    assign hz2.branch_taken    = hz.branch_taken;
    assign hz2.ID_EX_mem_read  = hz.ID_EX_mem_read;
    assign hz2.ID_EX_reg_write = hz.ID_EX_reg_write;
    assign hz2.ID_EX_rd        = hz.ID_EX_rd;
    assign hz2.EX_MEM_mem_read = hz.EX_MEM_mem_read;
    assign hz2.EX_MEM_rd       = hz.EX_MEM_rd;

    hazard_detection #(.CNT_W(16)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .hz          (hz),
        .stall_count (stall_count),
        .flush_count (flush_count)
    );

    hazard_detection #(.CNT_W(2)) dut2 (
        .clk         (clk),
        .rstn        (rstn),
        .hz          (hz2),
        .stall_count (stall_count2),
        .flush_count (flush_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        hz.IF_ID_rs        = 5'd0;
        hz.IF_ID_rt        = 5'd0;
        hz.IF_ID_branch    = 1'b0;
        hz.branch_taken    = 1'b0;
        hz.ID_EX_mem_read  = 1'b0;
        hz.ID_EX_reg_write = 1'b0;
        hz.ID_EX_rd        = 5'd0;
        hz.EX_MEM_mem_read = 1'b0;
        hz.EX_MEM_rd       = 5'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        clear_inputs();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Outputs packed as {pc_write, if_id_write, id_ex_flush, if_id_flush}
    task automatic test_reset();
        logic [3:0] got;
        rstn = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        got = {hz.pc_write, hz.if_id_write, hz.id_ex_flush, hz.if_id_flush};
        tests_run++;
        if (got !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 0000", got);
        end
        tests_run++;
        if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_count, flush_count);
        end
        rstn = 1'b1;
        #1;
        got = {hz.pc_write, hz.if_id_write, hz.id_ex_flush, hz.if_id_flush};
        tests_run++;
        if (got !== 4'b1100) begin
            tests_failed++;
            $display("FAIL idle_outputs: got %b expected 1100", got);
        end
    endtask

    task automatic test_load_use();
        logic [3:0] got;
        do_reset();
        hz.ID_EX_mem_read = 1'b1; hz.ID_EX_reg_write = 1'b1; hz.ID_EX_rd = 5'd2;
        hz.IF_ID_rs = 5'd2; hz.IF_ID_rt = 5'd4;
        #1;
        got = {hz.pc_write, hz.if_id_write, hz.id_ex_flush, hz.if_id_flush};
        tests_run++;
        if (got !== 4'b0010) begin
            tests_failed++;
            $display("FAIL load_use_stall: got %b expected 0010", got);
        end
        @(negedge clk);
        hz.ID_EX_mem_read = 1'b0; hz.ID_EX_reg_write = 1'b0; hz.ID_EX_rd = 5'd0;
        hz.EX_MEM_mem_read = 1'b1; hz.EX_MEM_rd = 5'd2;
        #1;
        got = {hz.pc_write, hz.if_id_write, hz.id_ex_flush, hz.if_id_flush};
        tests_run++;
        if (got !== 4'b1100) begin
            tests_failed++;
            $display("FAIL load_use_release: got %b expected 1100", got);
        end
        @(negedge clk);
        tests_run++;
        if (stall_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL load_use_count: got %0d expected 1", stall_count);
        end
    endtask

    task automatic test_branch_load();
        logic [3:0] got;
        do_reset();
        hz.IF_ID_branch = 1'b1; hz.branch_taken = 1'b1;
        hz.IF_ID_rs = 5'd2; hz.IF_ID_rt = 5'd5;
        hz.ID_EX_mem_read = 1'b1; hz.ID_EX_reg_write = 1'b1; hz.ID_EX_rd = 5'd2;
        #1;
        got = {hz.pc_write, hz.if_id_write, hz.id_ex_flush, hz.if_id_flush};
        tests_run++;
        if (got !== 4'b0010) begin
            tests_failed++;
            $display("FAIL branch_load_cycle1: got %b expected 0010", got);
        end
        @(negedge clk);
        hz.ID_EX_mem_read = 1'b0; hz.ID_EX_reg_write = 1'b0; hz.ID_EX_rd = 5'd0;
        #1;
        got = {hz.pc_write, hz.if_id_write, hz.id_ex_flush, hz.if_id_flush};
        tests_run++;
        if (got !== 4'b0010) begin
            tests_failed++;
            $display("FAIL branch_load_hold: got %b expected 0010", got);
        end
        @(negedge clk);
        #1;
        got = {hz.pc_write, hz.if_id_write, hz.id_ex_flush, hz.if_id_flush};
        tests_run++;
        if (got !== 4'b1101) begin
            tests_failed++;
            $display("FAIL branch_load_resolve: got %b expected 1101", got);
        end
        @(negedge clk);
        clear_inputs();
        tests_run++;
        if (stall_count !== 16'd2 || flush_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL branch_load_counts: got %0d/%0d expected 2/1", stall_count, flush_count);
        end
    endtask

    task automatic test_branch_alu();
        logic [3:0] got;
        do_reset();
        hz.IF_ID_branch = 1'b1; hz.branch_taken = 1'b1;
        hz.IF_ID_rs = 5'd0; hz.IF_ID_rt = 5'd7;
        hz.ID_EX_reg_write = 1'b1; hz.ID_EX_rd = 5'd7;
        #1;
        got = {hz.pc_write, hz.if_id_write, hz.id_ex_flush, hz.if_id_flush};
        tests_run++;
        if (got !== 4'b0010) begin
            tests_failed++;
            $display("FAIL branch_alu_stall: got %b expected 0010", got);
        end
        @(negedge clk);
        hz.ID_EX_reg_write = 1'b0; hz.ID_EX_rd = 5'd0; hz.EX_MEM_rd = 5'd7;
        #1;
        got = {hz.pc_write, hz.if_id_write, hz.id_ex_flush, hz.if_id_flush};
        tests_run++;
        if (got !== 4'b1101) begin
            tests_failed++;
            $display("FAIL branch_alu_flush: got %b expected 1101", got);
        end
        @(negedge clk);
        clear_inputs();
        tests_run++;
        if (stall_count !== 16'd1 || flush_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL branch_alu_counts: got %0d/%0d expected 1/1", stall_count, flush_count);
        end
    endtask

    task automatic test_branch_mem_load();
        logic [3:0] got;
        do_reset();
        hz.IF_ID_branch = 1'b1; hz.IF_ID_rs = 5'd9; hz.IF_ID_rt = 5'd1;
        hz.EX_MEM_mem_read = 1'b1; hz.EX_MEM_rd = 5'd9;
        #1;
        got = {hz.pc_write, hz.if_id_write, hz.id_ex_flush, hz.if_id_flush};
        tests_run++;
        if (got !== 4'b0010) begin
            tests_failed++;
            $display("FAIL branch_mem_load_stall: got %b expected 0010", got);
        end
        @(negedge clk);
        hz.EX_MEM_mem_read = 1'b0; hz.EX_MEM_rd = 5'd0;
        #1;
        got = {hz.pc_write, hz.if_id_write, hz.id_ex_flush, hz.if_id_flush};
        tests_run++;
        if (got !== 4'b1100) begin
            tests_failed++;
            $display("FAIL branch_mem_load_release: got %b expected 1100", got);
        end
    endtask

    task automatic test_zero_reg();
        logic [3:0] got;
        do_reset();
        hz.ID_EX_mem_read = 1'b1; hz.ID_EX_rd = 5'd0;
        hz.IF_ID_rs = 5'd0; hz.IF_ID_rt = 5'd0;
        #1;
        got = {hz.pc_write, hz.if_id_write, hz.id_ex_flush, hz.if_id_flush};
        tests_run++;
        if (got !== 4'b1100) begin
            tests_failed++;
            $display("FAIL zero_reg_no_stall: got %b expected 1100", got);
        end
        @(negedge clk);
        clear_inputs();
        hz.IF_ID_branch = 1'b1; hz.branch_taken = 1'b1; hz.IF_ID_rs = 5'd3; hz.IF_ID_rt = 5'd4;
        #1;
        got = {hz.pc_write, hz.if_id_write, hz.id_ex_flush, hz.if_id_flush};
        tests_run++;
        if (got !== 4'b1101) begin
            tests_failed++;
            $display("FAIL taken_no_hazard: got %b expected 1101", got);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reset_mid_hold();
        logic [3:0] got;
        do_reset();
        hz.IF_ID_branch = 1'b1; hz.IF_ID_rs = 5'd6;
        hz.ID_EX_mem_read = 1'b1; hz.ID_EX_rd = 5'd6;
        @(negedge clk);
        clear_inputs();
        #2;
        rstn = 1'b0;
        #1;
        got = {hz.pc_write, hz.if_id_write, hz.id_ex_flush, hz.if_id_flush};
        tests_run++;
        if (got !== 4'b0000) begin
            tests_failed++;
            $display("FAIL mid_hold_reset_outputs: got %b expected 0000", got);
        end
        tests_run++;
        if (stall_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL mid_hold_reset_count: got %0d expected 0", stall_count);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        got = {hz.pc_write, hz.if_id_write, hz.id_ex_flush, hz.if_id_flush};
        tests_run++;
        if (got !== 4'b1100 || stall_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL mid_hold_release: got %b/%0d expected 1100/0", got, stall_count);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        hz.ID_EX_mem_read = 1'b1; hz.ID_EX_rd = 5'd8; hz.IF_ID_rt = 5'd8;
        repeat (5) @(negedge clk);
        clear_inputs();
        tests_run++;
        if (stall_count2 !== 2'd3) begin
            tests_failed++;
            $display("FAIL saturate_cnt2: got %0d expected 3", stall_count2);
        end
        tests_run++;
        if (stall_count !== 16'd5) begin
            tests_failed++;
            $display("FAIL count_cnt16: got %0d expected 5", stall_count);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rstn         = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch_load();
        test_branch_alu();
        test_branch_mem_load();
        test_zero_reg();
        test_reset_mid_hold();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
